nvram_uploader: RTL and testbench
=================================

Name: nvram_uploader

Overview:
- Read-side counterpart of the ROM/NVRAM download path. Serves the hps_io upload handshake (ioctl_upload/ioctl_rd/ioctl_addr/ioctl_din/ioctl_wait) by reading the Williams CMOS high-score RAM through its second read port, so the OSD can save NVRAM to SD.
- Tracks a dirty flag from CPU CMOS writes, so the top level knows when a save is worthwhile.
- Sits in emu between hps_io and williams2, on clk_sys (12 MHz).

Parameters:
- ADDR_W, 10, CMOS address width; DEPTH = 2**ADDR_W entries (1024).
- DATA_W, 4, CMOS data width (nibble RAM).
- PAD, 4'hF, upper-nibble pad value for each uploaded byte.
- NV_INDEX, 16'd4, ioctl_index value that selects the NVRAM upload.

Ports:
- clk_sys, in, 1, system clock; all logic is on its rising edge.
- reset, in, 1, synchronous active-high reset.
- ioctl_upload, in, 1, hps_io upload active.
- ioctl_index, in, 16, upload target index.
- ioctl_rd, in, 1, one-cycle read strobe for the byte at ioctl_addr.
- ioctl_addr, in, 25, byte address of the request.
- ioctl_din, out, 8, returned byte; valid when ioctl_wait is low after a request.
- ioctl_wait, out, 1, stall toward hps_io.
- cmos_rd_addr, out, ADDR_W, CMOS second-port read address.
- cmos_rd_data, in, DATA_W, CMOS read data; registered, valid 1 cycle after the address.
- cpu_cmos_we, in, 1, CPU write strobe into CMOS (core clk_sys domain).
- nvram_dirty, out, 1, CMOS has changed since the last complete upload.
- upload_busy, out, 1, high while selected (ioctl_upload && ioctl_index==NV_INDEX).

Behaviour:
- Define sel = ioctl_upload && ioctl_index==NV_INDEX. upload_busy = sel, registered.
- Reset values: ioctl_din=8'h00, ioctl_wait=0, cmos_rd_addr=0, nvram_dirty=0, upload_busy=0, FSM=IDLE, complete flag=0.
- FSM states: IDLE, ADDR, RAM, DONE.
- IDLE: when sel && ioctl_rd at cycle T:
  - Latch ioctl_addr.
  - If addr < DEPTH: drive cmos_rd_addr=addr[ADDR_W-1:0] and go to ADDR.
  - Otherwise go to ADDR with an out-of-range flag set.
- ADDR (T+1): RAM lookup in flight; go to RAM.
- RAM (T+2): capture ioctl_din = {PAD, cmos_rd_data}, or 8'hFF if out-of-range; go to DONE.
- DONE (T+3): data stable; go to IDLE.
- ioctl_wait is combinational: high when ioctl_rd&&sel in IDLE, or FSM in ADDR or RAM. It is low in DONE and IDLE, so wait is high at T, T+1, T+2 and low at T+3.
- ioctl_din holds its last value until the next capture.
- ioctl_rd while not in IDLE is ignored; hps_io must not issue it while wait is high. No queuing.
- ioctl_rd with sel=0: ignored; wait stays 0.
- sel falls mid-fetch: FSM returns to IDLE next cycle, wait=0, no capture, complete not updated.
- Completion: complete sets when the request with addr==DEPTH-1 finishes (DONE state). When sel falls with complete=1, nvram_dirty clears and complete clears. complete also clears on every sel rising edge.
- Dirty: cpu_cmos_we sets nvram_dirty in the next cycle. A cpu_cmos_we at any point during an upload also clears complete, so the save is treated as stale and dirty stays set.
- Simultaneous cpu_cmos_we and the clear event: set wins; nvram_dirty=1.
- Address wrap: only addresses ≥DEPTH go out-of-range, even if they wrap in the low ADDR_W bits; those return 8'hFF and never touch CMOS.
- Reset mid-fetch: outputs return to reset values on the next edge, regardless of state.

Test Plan:
- Reset while FSM is in RAM -> next cycle ioctl_wait=0, ioctl_din=8'h00, nvram_dirty=0, FSM=IDLE.
- Preload CMOS[5]=4'h3, sel=1, pulse ioctl_rd with addr 5 at T -> cmos_rd_addr=5 at T+1; wait high at T..T+2; ioctl_din=8'hF3 and wait=0 at T+3.
- ioctl_rd with addr 1024 -> ioctl_din=8'hFF after the same 3-cycle latency; cmos_rd_addr unchanged.
- Pulse cpu_cmos_we -> nvram_dirty=1. Upload addrs 0..1023 sequentially, then drop ioctl_upload -> nvram_dirty=0 one cycle later.
- Same full upload with cpu_cmos_we at addr 500 -> nvram_dirty stays 1 after ioctl_upload falls.
- ioctl_index=0 with ioctl_rd -> ioctl_wait never asserts and ioctl_din is unchanged. Separately, drop ioctl_upload at T+1 of a fetch -> wait=0 at T+2 and ioctl_din is unchanged.

Source files
------------

// File: rtl/nvram_uploader.sv
// ---------------------------------------------------------------------------
// nvram_uploader
//
// Serves the hps_io upload handshake for the Williams CMOS high-score RAM so
// the OSD can save NVRAM to SD. Each ioctl_rd request is answered by reading
// one nibble through the CMOS second read port. The nibble is returned as a
// byte padded with PAD in the upper bits. The module also tracks whether CMOS
// has been written by the CPU since the last complete upload.
//
// Ports (all synchronous to clk_sys):
//   reset          synchronous active-high reset
//   ioctl_upload   hps_io upload active
//   ioctl_index    upload target index; NV_INDEX selects this block
//   ioctl_rd       one-cycle read strobe for the byte at ioctl_addr
//   ioctl_addr     byte address of the request
//   ioctl_din      returned byte, valid when ioctl_wait drops after a request
//   ioctl_wait     stall toward hps_io
//   cmos_rd_addr   CMOS second-port read address
//   cmos_rd_data   CMOS read data, registered, one cycle after the address
//   cpu_cmos_we    CPU write strobe into CMOS
//   nvram_dirty    CMOS changed since the last complete upload
//   upload_busy    registered copy of the select condition
// ---------------------------------------------------------------------------
module nvram_uploader #(
  parameter int                ADDR_W   = 10,
  parameter int                DATA_W   = 4,
  parameter logic [7-DATA_W:0] PAD      = 4'hF,
  parameter logic [15:0]       NV_INDEX = 16'd4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic [15:0]       ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] cmos_rd_addr,
  input  logic [DATA_W-1:0] cmos_rd_data,
  input  logic              cpu_cmos_we,
  output logic              nvram_dirty,
  output logic              upload_busy
);

  localparam int          DEPTH      = 1 << ADDR_W;
  localparam logic [24:0] DEPTH_ADDR = 25'(DEPTH);
  localparam logic [24:0] LAST_ADDR  = 25'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, ADDR, RAM, DONE} state_t;

  state_t            state_reg, state_next;
  logic [7:0]        din_reg, din_next;
  logic [ADDR_W-1:0] rd_addr_reg, rd_addr_next;
  logic              dirty_reg, dirty_next;
  logic              busy_reg;
  logic              complete_reg, complete_next;
  logic              stale_reg, stale_next;
  logic              oor_reg, oor_next;
  logic              last_reg, last_next;

  logic sel;
  logic sel_rise;
  logic sel_fall;

  assign sel      = ioctl_upload && (ioctl_index == NV_INDEX);
  // busy_reg is the previous-cycle sel, so it doubles as the edge detector.
  assign sel_rise = sel && !busy_reg;
  assign sel_fall = !sel && busy_reg;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg    <= IDLE;
      din_reg      <= 8'h00;
      rd_addr_reg  <= '0;
      dirty_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      complete_reg <= 1'b0;
      stale_reg    <= 1'b0;
      oor_reg      <= 1'b0;
      last_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      din_reg      <= din_next;
      rd_addr_reg  <= rd_addr_next;
      dirty_reg    <= dirty_next;
      busy_reg     <= sel;
      complete_reg <= complete_next;
      stale_reg    <= stale_next;
      oor_reg      <= oor_next;
      last_reg     <= last_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    din_next     = din_reg;
    rd_addr_next = rd_addr_reg;
    oor_next     = oor_reg;
    last_next    = last_reg;
    ioctl_wait   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (sel && ioctl_rd) begin
          ioctl_wait = 1'b1;
          state_next = ADDR;
          // Compare the full 25-bit address so aliases above DEPTH never
          // reach CMOS even though their low bits look valid.
          oor_next   = (ioctl_addr >= DEPTH_ADDR);
          last_next  = (ioctl_addr == LAST_ADDR);
          if (ioctl_addr < DEPTH_ADDR)
            rd_addr_next = ioctl_addr[ADDR_W-1:0];
        end
      end
      ADDR: begin
        ioctl_wait = 1'b1;
        state_next = sel ? RAM : IDLE;
      end
      RAM: begin
        ioctl_wait = 1'b1;
        if (sel) begin
          din_next   = oor_reg ? 8'hFF : {PAD, cmos_rd_data};
          state_next = DONE;
        end else begin
          state_next = IDLE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Completion / staleness / dirty bookkeeping. Later assignments win, so
  // the ordering below encodes the priorities: a CPU write always beats a
  // completion or a clear.
  always_comb begin
    complete_next = complete_reg;
    stale_next    = stale_reg;
    dirty_next    = dirty_reg;

    if (state_reg == DONE && last_reg && sel && !stale_reg)
      complete_next = 1'b1;

    if (sel_fall && complete_reg) begin
      complete_next = 1'b0;
      dirty_next    = 1'b0;
    end

    if (sel_rise) begin
      complete_next = 1'b0;
      stale_next    = 1'b0;
    end

    // A write during an upload makes the snapshot being saved stale for
    // the rest of this upload, so the final address cannot mark it complete.
    if (cpu_cmos_we && (sel || busy_reg)) begin
      complete_next = 1'b0;
      stale_next    = 1'b1;
    end

    if (cpu_cmos_we)
      dirty_next = 1'b1;
  end

  assign ioctl_din    = din_reg;
  assign cmos_rd_addr = rd_addr_reg;
  assign nvram_dirty  = dirty_reg;
  assign upload_busy  = busy_reg;

endmodule

// File: tb/tb_nvram_uploader.sv
// ---------------------------------------------------------------------------
// tb_nvram_uploader
//
// Directed bench for nvram_uploader. A behavioural CMOS second port (array
// with registered read) answers cmos_rd_addr. Expected bytes are built from
// the bench's own preload pattern.
// ---------------------------------------------------------------------------
module tb_nvram_uploader;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_upload;
  logic [15:0] ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic [9:0]  cmos_rd_addr;
  logic [3:0]  cmos_rd_data;
  logic        cpu_cmos_we;
  logic        nvram_dirty;
  logic        upload_busy;

  int errors = 0;
  int checks = 0;

  logic [3:0] mem [0:1023];
  logic [9:0] exp_rd_addr;

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cmos_rd_data <= mem[cmos_rd_addr];

  nvram_uploader dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ioctl_upload (ioctl_upload),
    .ioctl_index  (ioctl_index),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .ioctl_wait   (ioctl_wait),
    .cmos_rd_addr (cmos_rd_addr),
    .cmos_rd_data (cmos_rd_data),
    .cpu_cmos_we  (cpu_cmos_we),
    .nvram_dirty  (nvram_dirty),
    .upload_busy  (upload_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [7:0] exp_byte(input logic [24:0] a);
    if (a >= 25'd1024) return 8'hFF;
    return {4'hF, mem[a[9:0]]};
  endfunction

  // Full request: strobe at T, check wait at T..T+2, data at T+3.
  task automatic read_byte(input logic [24:0] a, input bit verbose);
    logic [7:0] e;
    e = exp_byte(a);
    step();
    ioctl_rd   = 1'b1;
    ioctl_addr = a;
    #1;
    if (verbose) check("wait_T", ioctl_wait, 1'b1);
    step();
    ioctl_rd = 1'b0;
    if (a < 25'd1024) exp_rd_addr = a[9:0];
    if (verbose) begin
      check("wait_T1", ioctl_wait, 1'b1);
      check("rd_addr_T1", cmos_rd_addr, exp_rd_addr);
    end
    step();
    if (verbose) check("wait_T2", ioctl_wait, 1'b1);
    step();
    if (verbose) check("wait_T3", ioctl_wait, 1'b0);
    check($sformatf("din@%0h", a), ioctl_din, e);
    if (verbose) $display("rd addr=%0h din=%02h exp=%02h", a, ioctl_din, e);
  endtask

  task automatic pulse_we;
    step();
    cpu_cmos_we = 1'b1;
    step();
    cpu_cmos_we = 1'b0;
  endtask

  task automatic full_upload(input bit we_mid);
    ioctl_upload = 1'b1;
    ioctl_index  = 16'd4;
    step();
    for (int a = 0; a < 1024; a++) begin
      if (we_mid && a == 500) pulse_we();
      read_byte(25'(a), 1'b0);
    end
    $display("upload sweep done we_mid=%0d dirty=%0d", we_mid, nvram_dirty);
    check("dirty_before_drop", nvram_dirty, 1'b1);
    step();
    ioctl_upload = 1'b0;
    step();
    check("dirty_after_drop", nvram_dirty, we_mid ? 1'b1 : 1'b0);
    step();
    check("dirty_after_drop2", nvram_dirty, we_mid ? 1'b1 : 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 4'(i) ^ 4'(i >> 4) ^ 4'h9;
    mem[5] = 4'h3;
    mem[7] = 4'hA;
    mem[3] = 4'h6;
    exp_rd_addr  = '0;
    reset        = 1'b1;
    ioctl_upload = 1'b0;
    ioctl_index  = 16'd0;
    ioctl_rd     = 1'b0;
    ioctl_addr   = '0;
    cpu_cmos_we  = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
    check("rst_din", ioctl_din, 8'h00);
    check("rst_wait", ioctl_wait, 1'b0);
    check("rst_rd_addr", cmos_rd_addr, 10'd0);
    check("rst_dirty", nvram_dirty, 1'b0);
    check("rst_busy", upload_busy, 1'b0);

    // Basic reads, out-of-range and aliasing addresses.
    ioctl_upload = 1'b1;
    ioctl_index  = 16'd4;
    step();
    check("busy_on", upload_busy, 1'b1);
    read_byte(25'd5, 1'b1);
    read_byte(25'd1024, 1'b1);
    read_byte(25'd1029, 1'b1);
    read_byte(25'd7, 1'b1);
    read_byte(25'h1FF_FFFF, 1'b1);

    // Dirty set, then reset while the FSM is in RAM.
    pulse_we();
    check("dirty_set", nvram_dirty, 1'b1);
    step();
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'd9;
    step();
    ioctl_rd = 1'b0;
    step();
    reset = 1'b1;
    step();
    check("rst_mid_wait", ioctl_wait, 1'b0);
    check("rst_mid_din", ioctl_din, 8'h00);
    check("rst_mid_dirty", nvram_dirty, 1'b0);
    check("rst_mid_rd_addr", cmos_rd_addr, 10'd0);
    check("rst_mid_busy", upload_busy, 1'b0);
    reset = 1'b0;
    exp_rd_addr = '0;
    step();

    // Non-selected index: strobe ignored.
    read_byte(25'd7, 1'b1);
    ioctl_index = 16'd0;
    step();
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'd3;
    #1;
    check("nosel_wait_T", ioctl_wait, 1'b0);
    step();
    ioctl_rd = 1'b0;
    check("nosel_wait_T1", ioctl_wait, 1'b0);
    step();
    check("nosel_wait_T2", ioctl_wait, 1'b0);
    step();
    check("nosel_din", ioctl_din, 8'hFA);
    $display("rd idx=0 addr=3 din=%02h exp=fa", ioctl_din);

    // Upload drops at T+1 of a fetch: abort without capture.
    ioctl_index = 16'd4;
    step();
    step();
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'd3;
    step();
    ioctl_rd     = 1'b0;
    ioctl_upload = 1'b0;
    step();
    check("abort_wait_T2", ioctl_wait, 1'b0);
    step();
    check("abort_wait_T3", ioctl_wait, 1'b0);
    check("abort_din", ioctl_din, 8'hFA);
    $display("rd aborted addr=3 din=%02h exp=fa", ioctl_din);

    // Clean full upload clears dirty; a mid-upload CPU write keeps it set.
    pulse_we();
    check("dirty_set2", nvram_dirty, 1'b1);
    full_upload(1'b0);
    pulse_we();
    check("dirty_set3", nvram_dirty, 1'b1);
    full_upload(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
